// File: rtl/trg_veto_release.sv
// Veto release controller: holds the trigger veto until every masked SCROD has
// finished readout (or a timeout expires), then pulses TRG_VETO_RESET.
module trg_veto_release #(
  parameter int START_WINDOW = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        CLK_42MHZ,
  input  logic        RESET_N,
  input  logic        TRG_NEEDS_VETO,
  input  logic        TRG_FLOW_CTL_EN,
  input  logic [11:0] TRG_MASK,
  input  logic [11:0] SCROD_BUSY,
  input  logic [15:0] TIMEOUT_CYCLES,
  output logic        TRG_VETO_RESET,
  output logic        VETO_ACTIVE,
  output logic [15:0] TIMEOUT_COUNT,
  output logic [11:0] TIMEOUT_SCRODS,
  output logic [31:0] DEADTIME_CYCLES
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    WAIT_DONE  = 3'd2,
    RELEASE    = 3'd3,
    HOLD       = 3'd4
  } state_t;

  localparam logic [7:0] WIN_LAST = 8'(START_WINDOW - 1);

  state_t      state;
  logic [11:0] busy_sync [SYNC_STAGES];
  logic [11:0] busy_s;
  logic [11:0] mask_l;
  logic [7:0]  win_cnt;
  logic [15:0] to_cnt;
  logic        all_done;
  logic        timed_out;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // SCROD_BUSY synchronizer chain (asynchronous source)
  always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) busy_sync[i] <= '0;
    end else begin
      busy_sync[0] <= SCROD_BUSY;
      for (int i = 1; i < SYNC_STAGES; i++) busy_sync[i] <= busy_sync[i-1];
    end
  end

  assign busy_s      = busy_sync[SYNC_STAGES-1];
  assign all_done    = ((busy_s & mask_l) == 12'd0);
  assign timed_out   = (TIMEOUT_CYCLES != 16'd0) && (to_cnt >= TIMEOUT_CYCLES);
  assign VETO_ACTIVE = (state != IDLE);

  // Release FSM with diagnostics counters
  always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state           <= IDLE;
      mask_l          <= '0;
      win_cnt         <= '0;
      to_cnt          <= '0;
      TRG_VETO_RESET  <= 1'b0;
      TIMEOUT_COUNT   <= '0;
      TIMEOUT_SCRODS  <= '0;
      DEADTIME_CYCLES <= '0;
    end else begin
      TRG_VETO_RESET <= 1'b0;
      if (state != IDLE) DEADTIME_CYCLES <= sat_inc32(DEADTIME_CYCLES);
      if (state == WAIT_START || state == WAIT_DONE) to_cnt <= sat_inc16(to_cnt);

      // Generator self-clears when flow control is withdrawn, so just drop out.
      if (state != IDLE && !TRG_FLOW_CTL_EN) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (TRG_NEEDS_VETO && TRG_FLOW_CTL_EN) begin
              mask_l  <= TRG_MASK;
              win_cnt <= '0;
              to_cnt  <= '0;
              state   <= WAIT_START;
            end
          end
          WAIT_START: begin
            if (!TRG_NEEDS_VETO) state <= IDLE;
            else if (win_cnt == WIN_LAST) state <= WAIT_DONE;
            else win_cnt <= win_cnt + 8'd1;
          end
          WAIT_DONE: begin
            if (!TRG_NEEDS_VETO) begin
              state <= IDLE;
            end else if (all_done) begin
              state          <= RELEASE;
              TRG_VETO_RESET <= 1'b1;
            end else if (timed_out) begin
              TIMEOUT_SCRODS <= busy_s & mask_l;
              TIMEOUT_COUNT  <= sat_inc16(TIMEOUT_COUNT);
              state          <= RELEASE;
              TRG_VETO_RESET <= 1'b1;
            end
          end
          RELEASE: state <= HOLD;
          HOLD: begin
            if (!TRG_NEEDS_VETO) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/trg_veto_release.md
Name: trg_veto_release

Overview:
- Sits directly downstream of the trigger generator and closes its flow-control loop.
- On TRG_NEEDS_VETO, tracks the BUSY lines of the SCRODs enabled in TRG_MASK until all masked SCRODs have finished readout, or a programmable timeout expires.
- Then pulses TRG_VETO_RESET so the trigger generator re-arms.
- Also accumulates dead-time and timeout diagnostics for the PCI register map.

Parameters:
START_WINDOW, 16, cycles to wait after veto onset before BUSY lines are evaluated (SCROD BUSY rise latency); range 1..255
SYNC_STAGES, 2, synchronizer depth on SCROD_BUSY; range 2..3

Ports:
CLK_42MHZ  in  1  system clock; all logic on its rising edge
RESET_N  in  1  asynchronous, active-low reset
TRG_NEEDS_VETO  in  1  level from trigger generator; high while it holds off triggers
TRG_FLOW_CTL_EN  in  1  flow control enable; low = block passive
TRG_MASK  in  12  SCRODs participating; latched at veto onset
SCROD_BUSY  in  12  per-SCROD readout busy, asynchronous to CLK_42MHZ
TIMEOUT_CYCLES  in  16  timeout measured from veto onset; 0 = no timeout
TRG_VETO_RESET  out  1  one-cycle pulse to trigger generator
VETO_ACTIVE  out  1  high whenever FSM is not IDLE
TIMEOUT_COUNT  out  16  number of timed-out vetoes, saturating at 0xFFFF
TIMEOUT_SCRODS  out  12  masked SCRODs still busy at the most recent timeout
DEADTIME_CYCLES  out  32  cycles with VETO_ACTIVE high, saturating at 0xFFFFFFFF

Behaviour:
- Reset (RESET_N low, asynchronous): FSM=IDLE; every output 0; latched mask, window counter and timeout counter 0; synchronizer flops 0.
- SCROD_BUSY passes through SYNC_STAGES flops per bit; busy_s is the synchronized value. Latency is SYNC_STAGES cycles.
- all_done = ((busy_s & mask_l) == 0).
- FSM states: IDLE, WAIT_START, WAIT_DONE, RELEASE, HOLD.
  - IDLE:
    - If TRG_NEEDS_VETO=1 and TRG_FLOW_CTL_EN=1: latch mask_l <= TRG_MASK, clear window/timeout counters, go to WAIT_START.
  - WAIT_START:
    - Window counter increments each cycle.
    - When it reaches START_WINDOW-1, go to WAIT_DONE; busy is ignored until then.
  - WAIT_DONE:
    - If all_done, go to RELEASE.
    - Else if TIMEOUT_CYCLES!=0 and timeout counter >= TIMEOUT_CYCLES: TIMEOUT_SCRODS <= busy_s & mask_l, TIMEOUT_COUNT += 1 (saturating), go to RELEASE.
    - all_done takes priority over a timeout in the same cycle.
  - RELEASE:
    - TRG_VETO_RESET=1 for exactly this one cycle (registered output, asserted the cycle the FSM is in RELEASE).
    - Go to HOLD.
  - HOLD:
    - Wait until TRG_NEEDS_VETO=0, then go to IDLE.
    - Prevents a second release for the same veto, since the generator clears the veto one cycle after the pulse.
- Timeout counter: 16-bit; increments in WAIT_START and WAIT_DONE; saturates at 0xFFFF and never wraps.
- mask_l==0: all_done is true immediately after the window, so release occurs START_WINDOW+1 cycles after onset.
- Flow control disabled mid-operation: if TRG_FLOW_CTL_EN=0 in any state other than IDLE, go to IDLE next cycle. No pulse is issued and no timeout is counted, because the generator self-clears in that case.
- TRG_NEEDS_VETO dropping early (WAIT_START/WAIT_DONE): go to IDLE without a pulse.
- TRG_MASK and TIMEOUT_CYCLES changes after veto onset: TRG_MASK changes have no effect until the next veto. TIMEOUT_CYCLES is compared live.
- DEADTIME_CYCLES: +1 every cycle VETO_ACTIVE=1, saturating. It is cleared only by reset.
- VETO_ACTIVE: combinational decode of state != IDLE.
- Nominal release latency from a masked SCROD's BUSY falling edge to TRG_VETO_RESET: SYNC_STAGES+1 cycles, provided the window has elapsed.

Test Plan:
1. Mask=0x003, TIMEOUT=1000; NEEDS_VETO rises; BUSY[1:0] rise at +3 and fall at +40 and +60 -> single TRG_VETO_RESET pulse at cycle 60+SYNC_STAGES+1; TIMEOUT_COUNT=0; DEADTIME_CYCLES increments once per VETO_ACTIVE cycle.
2. Mask=0x801, TIMEOUT=100, BUSY[11] stuck high -> pulse one cycle after the timeout counter reaches 100; TIMEOUT_COUNT=1; TIMEOUT_SCRODS=0x800.
3. Mask=0x000, START_WINDOW=16 -> pulse at cycle 17 after onset; VETO_ACTIVE returns low once NEEDS_VETO drops; no timeout counted.
4. FLOW_CTL_EN dropped in WAIT_DONE -> FSM to IDLE next cycle; no pulse; TIMEOUT_COUNT unchanged.
5. RESET_N asserted asynchronously mid WAIT_DONE -> all outputs 0 immediately, without a clock edge; after release, a fresh veto completes normally.
6. Last busy SCROD falls in the same cycle the timeout expires -> release treated as normal completion; TIMEOUT_COUNT unchanged. Separately, force TIMEOUT_COUNT to 0xFFFF -> it stays at 0xFFFF after another timeout.
